// File: rtl/cache_controller_if.sv
// Bus bundle between the memory stage, the cache and the SRAM controller.
// The master side is the environment: it drives requests and SRAM responses.
interface cache_controller_if;
    logic [31:0] address;
    logic [31:0] wdata;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] rdata;
    logic        ready;
    logic [31:0] sram_address;
    logic [31:0] sram_wdata;
    logic        sram_r_en;
    logic        sram_w_en;
    logic [63:0] sram_rdata;
    logic        sram_ready;

    modport master (
        output address, wdata, mem_r_en, mem_w_en, sram_rdata, sram_ready,
        input  rdata, ready, sram_address, sram_wdata, sram_r_en, sram_w_en
    );

    modport slave (
        input  address, wdata, mem_r_en, mem_w_en, sram_rdata, sram_ready,
        output rdata, ready, sram_address, sram_wdata, sram_r_en, sram_w_en
    );
endinterface

// File: rtl/cache_controller.sv
// 2-way set-associative read cache with write-through, no write-allocate.
// Read hits complete combinationally; misses fill a 64-bit block from SRAM.
module cache_controller #(
    parameter int SETS  = 64,
    parameter int TAG_W = 10
) (
    input logic               clk,
    input logic               rst,
    cache_controller_if.slave bus
);
    localparam int IDX_W = $clog2(SETS);

    typedef enum logic [1:0] {IDLE, RD_MISS, WR} state_t;

    state_t           state;
    logic [63:0]      data0 [SETS];
    logic [63:0]      data1 [SETS];
    logic [TAG_W-1:0] tag0  [SETS];
    logic [TAG_W-1:0] tag1  [SETS];
    logic [SETS-1:0]  valid0;
    logic [SETS-1:0]  valid1;
    logic [SETS-1:0]  lru;

    logic [IDX_W-1:0] cur_idx, req_idx;
    logic [TAG_W-1:0] cur_tag, req_tag;
    logic             cur_word, req_word;
    logic             hit0, hit1, req_hit0, req_hit1, victim1;

    logic             ready;
    logic [31:0]      rdata;
    logic             sram_r_en, sram_w_en;
    logic [31:0]      sram_address, sram_wdata;

    assign cur_idx  = bus.address[3 +: IDX_W];
    assign cur_tag  = bus.address[3 + IDX_W +: TAG_W];
    assign cur_word = bus.address[2];

    assign hit0     = valid0[cur_idx] && (tag0[cur_idx] == cur_tag);
    assign hit1     = valid1[cur_idx] && (tag1[cur_idx] == cur_tag);
    assign req_hit0 = valid0[req_idx] && (tag0[req_idx] == req_tag);
    assign req_hit1 = valid1[req_idx] && (tag1[req_idx] == req_tag);

    // Invalid way0 first, then invalid way1, otherwise the LRU way.
    assign victim1  = valid0[req_idx] && (!valid1[req_idx] || lru[req_idx]);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        ready = 1'b1;
        rdata = '0;
        case (state)
            IDLE: begin
                if (bus.mem_w_en) begin
                    ready = 1'b0;
                end else if (bus.mem_r_en) begin
                    if (hit0)
                        rdata = cur_word ? data0[cur_idx][63:32] : data0[cur_idx][31:0];
                    else if (hit1)
                        rdata = cur_word ? data1[cur_idx][63:32] : data1[cur_idx][31:0];
                    else
                        ready = 1'b0;
                end
            end
            RD_MISS: begin
                ready = bus.sram_ready;
                if (bus.sram_ready)
                    rdata = req_word ? bus.sram_rdata[63:32] : bus.sram_rdata[31:0];
            end
            WR:      ready = bus.sram_ready;
            default: ready = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            state        <= IDLE;
            sram_r_en    <= 1'b0;
            sram_w_en    <= 1'b0;
            sram_address <= '0;
            sram_wdata   <= '0;
            req_idx      <= '0;
            req_tag      <= '0;
            req_word     <= 1'b0;
            valid0       <= '0;
            valid1       <= '0;
            lru          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.mem_w_en) begin
                        state        <= WR;
                        sram_w_en    <= 1'b1;
                        sram_address <= bus.address;
                        sram_wdata   <= bus.wdata;
                        req_idx      <= cur_idx;
                        req_tag      <= cur_tag;
                        req_word     <= cur_word;
                    end else if (bus.mem_r_en) begin
                        if (hit0) begin
                            lru[cur_idx] <= 1'b1;
                        end else if (hit1) begin
                            lru[cur_idx] <= 1'b0;
                        end else begin
                            state        <= RD_MISS;
                            sram_r_en    <= 1'b1;
                            sram_address <= {bus.address[31:3], 3'b000};
                            req_idx      <= cur_idx;
                            req_tag      <= cur_tag;
                            req_word     <= cur_word;
                        end
                    end
                end
                RD_MISS: begin
                    if (bus.sram_ready) begin
                        state     <= IDLE;
                        sram_r_en <= 1'b0;
                        if (victim1) begin
                            valid1[req_idx] <= 1'b1;
                            lru[req_idx]    <= 1'b0;
                        end else begin
                            valid0[req_idx] <= 1'b1;
                            lru[req_idx]    <= 1'b1;
                        end
                    end
                end
                WR: begin
                    if (bus.sram_ready) begin
                        state     <= IDLE;
                        sram_w_en <= 1'b0;
                        if (req_hit0)
                            valid0[req_idx] <= 1'b0;
                        else if (req_hit1)
                            valid1[req_idx] <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: data and tag arrays are not reset; the valid bits alone guard them.
    always_ff @(posedge clk) begin
        if (state == RD_MISS && bus.sram_ready) begin
            if (victim1) begin
                data1[req_idx] <= bus.sram_rdata;
                tag1[req_idx]  <= req_tag;
            end else begin
                data0[req_idx] <= bus.sram_rdata;
                tag0[req_idx]  <= req_tag;
            end
        end
    end

    assign bus.ready        = ready;
    assign bus.rdata        = rdata;
    assign bus.sram_r_en    = sram_r_en;
    assign bus.sram_w_en    = sram_w_en;
    assign bus.sram_address = sram_address;
    assign bus.sram_wdata   = sram_wdata;
endmodule

// File: tb/tb_cache_controller.sv
// Randomized bench for cache_controller: an SRAM responder with random latency,
// a transaction-level presence/LRU model, and a per-cycle compare process.
module tb_cache_controller;
    typedef enum {K_OFF, K_IDLE, K_RD, K_WR} kind_t;

    logic clk;
    logic rst;
    cache_controller_if bus ();

    cache_controller #(.SETS(64), .TAG_W(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    kind_t       kind  = K_OFF;
    int          cyc;
    logic [31:0] r_addr, r_wdata, exp_word;
    bit          exp_hit;
    bit          resp_en;
    logic [31:0] last_rdata;
    int          last_lat;

    // SRAM contents: written words override a fixed hash of the address.
    logic [31:0] mem_ovr [logic [31:0]];

    // Cache model: which block sits in which way, plus the victim pointer.
    bit          m_valid [2][64];
    logic [9:0]  m_tag   [2][64];
    bit          m_lru   [64];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        logic [31:0] wa;
        wa = {a[31:2], 2'b00};
        if (mem_ovr.exists(wa)) return mem_ovr[wa];
        return (wa * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic int model_way(input logic [31:0] a);
        for (int w = 0; w < 2; w++)
            if (m_valid[w][a[8:3]] && m_tag[w][a[8:3]] == a[18:9]) return w;
        return -1;
    endfunction

    task automatic model_clear();
        for (int s = 0; s < 64; s++) begin
            m_valid[0][s] = 0;
            m_valid[1][s] = 0;
            m_lru[s]      = 0;
        end
    endtask

    // SRAM controller: after a random delay, one-cycle ready pulse.
    initial begin
        int lat;
        bus.sram_ready = 1'b0;
        bus.sram_rdata = '0;
        forever begin
            @(negedge clk);
            if (resp_en && !rst && (bus.sram_r_en || bus.sram_w_en)) begin
                lat = $urandom_range(0, 3);
                repeat (lat) @(negedge clk);
                @(posedge clk);
                #1;
                if (bus.sram_w_en) mem_ovr[{bus.sram_address[31:2], 2'b00}] = bus.sram_wdata;
                bus.sram_rdata = {mem_rd(bus.sram_address | 32'h4), mem_rd(bus.sram_address & ~32'h4)};
                bus.sram_ready = 1'b1;
                @(posedge clk);
                #1;
                bus.sram_ready = 1'b0;
            end
        end
    end

    // Compare process: checks outputs every cycle against the model's view.
    always @(negedge clk) begin
        if (kind == K_IDLE) begin
            check("idle_ready", bus.ready, 1'b1);
            check("idle_sram_r_en", bus.sram_r_en, 1'b0);
            check("idle_sram_w_en", bus.sram_w_en, 1'b0);
        end else if (kind == K_RD && exp_hit) begin
            check("hit_ready", bus.ready, 1'b1);
            check("hit_rdata", bus.rdata, exp_word);
            check("hit_sram_r_en", bus.sram_r_en, 1'b0);
        end else if (kind == K_RD) begin
            if (cyc == 0) begin
                check("miss_first_ready", bus.ready, 1'b0);
                check("miss_first_r_en", bus.sram_r_en, 1'b0);
            end else begin
                check("miss_sram_r_en", bus.sram_r_en, 1'b1);
                check("miss_sram_addr", bus.sram_address, {r_addr[31:3], 3'b000});
                check("miss_ready", bus.ready, bus.sram_ready);
                if (bus.sram_ready) check("miss_rdata", bus.rdata, exp_word);
            end
        end else if (kind == K_WR) begin
            check("wr_sram_r_en", bus.sram_r_en, 1'b0);
            if (cyc == 0) begin
                check("wr_first_ready", bus.ready, 1'b0);
                check("wr_first_w_en", bus.sram_w_en, 1'b0);
            end else begin
                check("wr_sram_w_en", bus.sram_w_en, 1'b1);
                check("wr_sram_addr", bus.sram_address, r_addr);
                check("wr_sram_wdata", bus.sram_wdata, r_wdata);
                check("wr_ready", bus.ready, bus.sram_ready);
            end
        end
    end

    // Issue one request (called just after a rising edge), run it to completion, commit model.
    task automatic do_req(input bit wr, input bit both, input logic [31:0] a, input logic [31:0] d);
        bit        done;
        int        w, v;
        logic [5:0] idx;
        idx      = a[8:3];
        w        = model_way(a);
        r_addr   = a;
        r_wdata  = d;
        cyc      = 0;
        exp_hit  = !wr && (w >= 0);
        exp_word = mem_rd(a);
        bus.address  = a;
        bus.wdata    = d;
        bus.mem_w_en = wr;
        bus.mem_r_en = !wr || both;
        kind = wr ? K_WR : K_RD;
        done = 0;
        while (!done) begin
            @(negedge clk);
            if (bus.ready) begin
                done       = 1;
                last_rdata = bus.rdata;
                last_lat   = cyc;
            end
            @(posedge clk);
            #1;
            if (!done) begin
                cyc++;
                if (cyc > 40) begin
                    check("timeout_ready", bus.ready, 1'b1);
                    done     = 1;
                    last_lat = -1;
                end
            end
        end
        if (!wr) begin
            if (w >= 0) begin
                m_lru[idx] = (w == 0);
            end else begin
                v = !m_valid[0][idx] ? 0 : (!m_valid[1][idx] ? 1 : int'(m_lru[idx]));
                m_valid[v][idx] = 1;
                m_tag[v][idx]   = a[18:9];
                m_lru[idx]      = (v == 0);
            end
        end else if (w >= 0) begin
            m_valid[w][idx] = 0;
        end
        kind         = K_IDLE;
        bus.mem_r_en = 1'b0;
        bus.mem_w_en = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        int          r;
        rst          = 1'b1;
        resp_en      = 1'b1;
        bus.address  = '0;
        bus.wdata    = '0;
        bus.mem_r_en = 1'b0;
        bus.mem_w_en = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", bus.ready, 1'b1);
        check("rst_sram_r_en", bus.sram_r_en, 1'b0);
        check("rst_sram_w_en", bus.sram_w_en, 1'b0);
        check("rst_rdata", bus.rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        kind = K_IDLE;

        mem_ovr[32'h40] = 32'hAAAA_0001;
        mem_ovr[32'h44] = 32'hBBBB_0002;

        // Cold miss, then a hit on the other word of the same block.
        do_req(0, 0, 32'h40, 0);
        check("t1_rdata", last_rdata, 32'hAAAA_0001);
        check("t1_missed", last_lat > 0, 1'b1);
        do_req(0, 0, 32'h44, 0);
        check("t2_rdata", last_rdata, 32'hBBBB_0002);
        check("t2_lat", last_lat, 0);

        // Three tags on index 8: the third fill evicts 0x040.
        do_req(0, 0, 32'h240, 0);
        do_req(0, 0, 32'h440, 0);
        do_req(0, 0, 32'h240, 0);
        check("t3_240_hit_lat", last_lat, 0);
        do_req(0, 0, 32'h40, 0);
        check("t3_040_missed", last_lat > 0, 1'b1);
        check("t3_040_rdata", last_rdata, 32'hAAAA_0001);

        // Write hit invalidates the line; the next read refetches the new word.
        do_req(1, 0, 32'h44, 32'h1234_5678);
        do_req(0, 0, 32'h44, 0);
        check("t4_missed", last_lat > 0, 1'b1);
        check("t4_rdata", last_rdata, 32'h1234_5678);

        // Write to an uncached address leaves set 0 intact.
        do_req(0, 0, 32'h0, 0);
        do_req(1, 0, 32'h800, 32'hCAFE_F00D);
        do_req(0, 0, 32'h0, 0);
        check("t5_set0_still_hit", last_lat, 0);
        do_req(0, 0, 32'h800, 0);
        check("t5_800_missed", last_lat > 0, 1'b1);
        check("t5_800_rdata", last_rdata, 32'hCAFE_F00D);

        // Reset in the middle of a miss.
        resp_en      = 1'b0;
        kind         = K_OFF;
        bus.address  = 32'h1040;
        bus.mem_r_en = 1'b1;
        @(posedge clk);
        #1;
        check("t6_r_en_before", bus.sram_r_en, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        check("t6_r_en_in_reset", bus.sram_r_en, 1'b0);
        bus.mem_r_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        model_clear();
        resp_en = 1'b1;
        kind    = K_IDLE;
        do_req(0, 0, 32'h1040, 0);
        check("t6_missed_after_reset", last_lat > 0, 1'b1);
        do_req(0, 0, 32'h40, 0);
        check("t6_cache_empty", last_lat > 0, 1'b1);

        // Random traffic over 4 tags x 4 sets so hits, evictions and invalidations mix.
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            a = {13'b0, 10'($urandom_range(0, 3)), 6'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 2'b00};
            if (r < 10) begin
                kind = K_IDLE;
                repeat ($urandom_range(1, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end else if (r < 70) begin
                do_req(0, 0, a, 0);
            end else begin
                do_req(1, r >= 90, a, $urandom);
            end
        end

        kind = K_OFF;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
